xsim_dma_burst: RTL and testbench
=================================

Name: xsim_dma_burst

Overview:
Simulation-only DMA bridge from BSV-generated logic to host memory via the DPI-C calls read_simDma32 and write_simDma32.
- Parametrised successor to the single-word DMA read/write model.
- Data path is DATAWIDTH bits wide, split into 32-bit DPI words.
- Supports multi-beat bursts with tags.
- Buffers read beats in a DEPTH-entry response FIFO, so up to DEPTH beats are outstanding under backpressure.
- Adds a tagged write-completion channel.

Parameters:
DATAWIDTH, 64, beat width in bits; multiple of 32, range 32..256.
DEPTH, 4, read-response FIFO entries; power of 2, ≥2.
MAXBURST, 16, maximum beats per burst.
TAGWIDTH, 4, request tag width.

Ports:
CLK  in  1  sole clock
RST  in  1  synchronous active-high reset
en_readreq  in  1  read request enable, legal only when rdy_readreq
rdy_readreq  out  1  read FSM idle
readreq_handle  in  32  DMA handle
readreq_addr  in  32  byte address of beat 0
readreq_len  in  $clog2(MAXBURST)+1  beat count
readreq_tag  in  TAGWIDTH  returned with every beat
rdy_readresp  out  1  FIFO not empty
en_readresp  in  1  dequeue
readresp_data  out  DATAWIDTH  head beat data
readresp_tag  out  TAGWIDTH  head beat tag
readresp_last  out  1  head is final beat of its burst
en_writereq / rdy_writereq  in/out  1  write request handshake
writereq_handle, writereq_addr  in  32  write target
writereq_len  in  $clog2(MAXBURST)+1  beat count
writereq_tag  in  TAGWIDTH  completion tag
en_writedata / rdy_writedata  in/out  1  write beat handshake
writedata_data  in  DATAWIDTH  write beat
rdy_writedone / en_writedone  out/in  1  completion handshake
writedone_tag  out  TAGWIDTH  tag of the completed write

Behaviour:
Reset and general rules
- While RST=1: every rdy_* output is 0; FSMs go to IDLE; FIFO and done register are emptied; data/tag outputs are 0; no DPI calls.
- From the first cycle after RST deasserts: rdy_readreq=rdy_writereq=1.
- Reset mid-burst drops remaining beats and issues no further DPI calls.
- W = DATAWIDTH/32 words per beat. Word k of beat b is at addr + b*(DATAWIDTH/8) + 4k, modulo 2^32 (wrap silently). Word 0 is the LSBs.
- len=0 is treated as 1; len>MAXBURST is clamped to MAXBURST.
- Enables asserted while the matching rdy is 0 are ignored.

Read FSM (IDLE, RBURST)
- IDLE→RBURST on en_readreq: latch handle, addr, len and tag; beat counter = 0.
- In RBURST, each cycle with (FIFO not full) OR (en_readresp this cycle):
  - Call read_simDma32 for all W words.
  - Push {data, tag, last = (counter == len-1)}.
  - Increment the counter.
- After pushing last, return to IDLE. rdy_readreq is high again the next cycle.
- Latency: first beat is visible at the FIFO head 2 cycles after the en_readreq edge. Steady state is 1 beat/cycle.
- FIFO full with a simultaneous dequeue: the push is permitted, and count is unchanged.

Write FSM (IDLE, WDATA, WDONE)
- IDLE→WDATA on en_writereq; latch the request fields.
- In WDATA, rdy_writedata=1. Each en_writedata calls write_simDma32 for all W words (ascending k) in that cycle.
- After the last beat: WDONE. rdy_writedone=1, writedone_tag is the latched tag.
- en_writedone→IDLE.
- Same-cycle read and write DPI calls: all writes are issued before all reads, so read-after-write to the same address sees the new data.

Decomposition:
- Package xsim_dma_pkg holds:
  - read_state_e and write_state_e enums.
  - BYTES_PER_WORD=4.
  - The parametrised beat struct {data, tag, last} via localparam widths.
- DPI imports stay in the shared xsim DPI import file.
- One sub-module, xsim_sync_fifo (WIDTH, DEPTH; synchronous, RST active-high, simultaneous enq/deq when full), is instantiated for the read response.

Test Plan:
1. DATAWIDTH=64; read handle=1, addr=0x100, len=4, tag=3, host words 0..7 = 0x10..0x17 → 4 beats 0x00000011_00000010 … 0x00000017_00000016, tag 3, last only on beat 4, first beat 2 cycles after request.
2. Same read with en_readresp held 0 → exactly DEPTH=4 beats buffered, no DPI reads beyond word 7. Then dequeue 1/cycle with no bubbles and no loss.
3. Write addr=0x200, len=2, tag=5, data 0xA_…_B, 0xC_…_D → four write_simDma32 calls in address order 0x200..0x20C. writedone_tag=5; rdy_writereq returns the cycle after en_writedone.
4. Read addr=0xFFFFFFF8, len=2, DATAWIDTH=64 → second beat uses words at 0x0 and 0x4 (wrap). Also len=0 → one beat with last=1.
5. RST asserted in the third beat of a len=8 read and mid-write → all rdy=0 the next cycle, FIFO empty, no further DPI calls. After release, a new len=1 read completes normally.
6. Write then read of the same address issued in the same cycle → read data equals the newly written data.

Source files
------------

// File: rtl/xsim_dma_pkg.sv
// Shared types and constants for the burst DMA bridge.
// Contents:
//   - the read and write FSM state enums
//   - the host word size
//   - a helper that sizes a packed response beat {data, tag, last}
package xsim_dma_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_BITS      = 32;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } read_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_DONE
  } write_state_e;

  // Width of a packed response beat: data, tag and a one-bit last flag.
  function automatic int unsigned beat_bits(input int unsigned data_w,
                                            input int unsigned tag_w);
    return data_w + tag_w + 1;
  endfunction

endpackage

// File: rtl/xsim_dpi_pkg.sv
// Host-side memory behind the read_simDma32 / write_simDma32 calls.
// In this stand-in, the C side is modelled in SystemVerilog. Host memory is a
// sparse word store keyed by {handle, byte address}. A missing word reads as 0.
// The write log and the read-call counter let a test bench observe the order
// and number of accesses made by the bridge.
package xsim_dpi_pkg;

  logic [31:0] host_mem [logic [63:0]];
  int unsigned read_calls;
  logic [31:0] wlog_handle [$];
  logic [31:0] wlog_addr   [$];
  logic [31:0] wlog_data   [$];

  function automatic logic [31:0] read_simDma32(input logic [31:0] handle,
                                                input logic [31:0] addr);
    read_calls++;
    if (host_mem.exists({handle, addr})) return host_mem[{handle, addr}];
    return '0;
  endfunction

  function automatic void write_simDma32(input logic [31:0] handle,
                                         input logic [31:0] addr,
                                         input logic [31:0] data);
    host_mem[{handle, addr}] = data;
    wlog_handle.push_back(handle);
    wlog_addr.push_back(addr);
    wlog_data.push_back(data);
  endfunction

  function automatic void host_poke(input logic [31:0] handle,
                                    input logic [31:0] addr,
                                    input logic [31:0] data);
    host_mem[{handle, addr}] = data;
  endfunction

endpackage

// File: rtl/xsim_sync_fifo.sv
// Synchronous FIFO holding the read-response beats.
// Ports:
//   clk, rst : clock and synchronous active-high reset (reset empties the FIFO)
//   enq      : push enq_data. Accepted when not full, or when full and a
//              dequeue happens in the same cycle.
//   deq      : pop the head. Ignored while empty.
//   head     : the current head entry
//   empty    : asserted when the FIFO holds no entries
//   count    : current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
module xsim_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_enq;
  logic             do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_deq = deq && !empty;
  assign do_enq = enq && (!full || do_deq);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_enq) - CW'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/xsim_dma_burst.sv
// Simulation DMA bridge with bursts and tags. Each DATAWIDTH-bit beat is
// carried as DATAWIDTH/32 host words through read_simDma32 / write_simDma32.
// Word k of beat b sits at addr + b*(DATAWIDTH/8) + 4k, and word 0 is the LSBs.
// Ports:
//   CLK, RST
//     Clock and synchronous active-high reset. While reset is high, every
//     rdy output is low and the data and tag outputs are 0.
//   en/rdy_readreq, readreq_handle/addr/len/tag
//     Start a read burst.
//   rdy/en_readresp, readresp_data/tag/last
//     Head of the read-response FIFO.
//   en/rdy_writereq, writereq_handle/addr/len/tag
//     Start a write burst.
//   en/rdy_writedata, writedata_data
//     One write beat per accepted cycle.
//   rdy/en_writedone, writedone_tag
//     Tagged completion of a write burst.
// A len of 0 is treated as 1. A len above MAXBURST is clamped to MAXBURST.
module xsim_dma_burst
  import xsim_dma_pkg::*;
  import xsim_dpi_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAXBURST  = 16,
  parameter int unsigned TAGWIDTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en_readreq,
  output logic                       rdy_readreq,
  input  logic [31:0]                readreq_handle,
  input  logic [31:0]                readreq_addr,
  input  logic [$clog2(MAXBURST):0]  readreq_len,
  input  logic [TAGWIDTH-1:0]        readreq_tag,
  output logic                       rdy_readresp,
  input  logic                       en_readresp,
  output logic [DATAWIDTH-1:0]       readresp_data,
  output logic [TAGWIDTH-1:0]        readresp_tag,
  output logic                       readresp_last,
  input  logic                       en_writereq,
  output logic                       rdy_writereq,
  input  logic [31:0]                writereq_handle,
  input  logic [31:0]                writereq_addr,
  input  logic [$clog2(MAXBURST):0]  writereq_len,
  input  logic [TAGWIDTH-1:0]        writereq_tag,
  input  logic                       en_writedata,
  output logic                       rdy_writedata,
  input  logic [DATAWIDTH-1:0]       writedata_data,
  output logic                       rdy_writedone,
  input  logic                       en_writedone,
  output logic [TAGWIDTH-1:0]        writedone_tag
);

  localparam int unsigned LW         = $clog2(MAXBURST) + 1;
  localparam int unsigned NW         = DATAWIDTH / WORD_BITS;
  localparam int unsigned BEAT_BYTES = DATAWIDTH / 8;
  localparam int unsigned CW         = $clog2(DEPTH) + 1;
  localparam int unsigned BEAT_W     = beat_bits(DATAWIDTH, TAGWIDTH);

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [TAGWIDTH-1:0]  tag;
    logic                 last;
  } beat_t;

  function automatic logic [LW-1:0] norm_len(input logic [LW-1:0] len);
    if (len == '0) return LW'(1);
    if (len > LW'(MAXBURST)) return LW'(MAXBURST);
    return len;
  endfunction

  // ---------------- read side ----------------
  read_state_e          rstate;
  read_state_e          rnext;
  logic [31:0]          rhandle;
  logic [31:0]          raddr;
  logic [LW-1:0]        rlen;
  logic [LW-1:0]        rcnt;
  logic [TAGWIDTH-1:0]  rtag;
  logic                 rd_fire;
  logic                 rd_last;
  logic                 rd_deq;

  beat_t                stg_beat;
  logic                 stg_valid;
  beat_t                head_beat;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        occupancy;

  // Beats are fetched one cycle before they enter the FIFO. Space is therefore
  // judged on FIFO entries plus the beat in flight, so no more than DEPTH beats
  // are ever outstanding.
  assign occupancy = fifo_count + CW'(stg_valid);
  assign rd_last   = (rcnt == rlen - LW'(1));
  assign rd_deq    = en_readresp && rdy_readresp;

  always_comb begin
    rnext       = rstate;
    rd_fire     = 1'b0;
    rdy_readreq = 1'b0;
    case (rstate)
      R_IDLE: begin
        rdy_readreq = !RST;
        if (en_readreq) rnext = R_BURST;
      end
      R_BURST: begin
        rd_fire = (occupancy < CW'(DEPTH)) || rd_deq;
        if (rd_fire && rd_last) rnext = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rstate  <= R_IDLE;
      rhandle <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rtag    <= '0;
    end else begin
      rstate <= rnext;
      if (rstate == R_IDLE && en_readreq) begin
        rhandle <= readreq_handle;
        raddr   <= readreq_addr;
        rlen    <= norm_len(readreq_len);
        rtag    <= readreq_tag;
        rcnt    <= '0;
      end else if (rd_fire) begin
        rcnt  <= rcnt + LW'(1);
        raddr <= raddr + 32'(BEAT_BYTES);
      end
    end
  end

  // ---------------- write side ----------------
  write_state_e         wstate;
  write_state_e         wnext;
  logic [31:0]          whandle;
  logic [31:0]          waddr;
  logic [LW-1:0]        wlen;
  logic [LW-1:0]        wcnt;
  logic [TAGWIDTH-1:0]  wtag;
  logic                 wr_fire;

  assign wr_fire = (wstate == W_DATA) && en_writedata;

  always_comb begin
    wnext         = wstate;
    rdy_writereq  = 1'b0;
    rdy_writedata = 1'b0;
    rdy_writedone = 1'b0;
    writedone_tag = '0;
    case (wstate)
      W_IDLE: begin
        rdy_writereq = !RST;
        if (en_writereq) wnext = W_DATA;
      end
      W_DATA: begin
        rdy_writedata = !RST;
        if (wr_fire && wcnt == wlen - LW'(1)) wnext = W_DONE;
      end
      W_DONE: begin
        rdy_writedone = !RST;
        writedone_tag = RST ? '0 : wtag;
        if (en_writedone) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate  <= W_IDLE;
      whandle <= '0;
      waddr   <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      wtag    <= '0;
    end else begin
      wstate <= wnext;
      if (wstate == W_IDLE && en_writereq) begin
        whandle <= writereq_handle;
        waddr   <= writereq_addr;
        wlen    <= norm_len(writereq_len);
        wtag    <= writereq_tag;
        wcnt    <= '0;
      end else if (wr_fire) begin
        wcnt  <= wcnt + LW'(1);
        waddr <= waddr + 32'(BEAT_BYTES);
      end
    end
  end

  // ---------------- host access ----------------
  // All host calls live in this one block. Write calls are issued before read
  // calls, so a same-cycle read of a word that is also being written returns
  // the new value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stg_valid <= 1'b0;
      stg_beat  <= '0;
    end else begin
      if (wr_fire) begin
        for (int unsigned k = 0; k < NW; k++) begin
          write_simDma32(whandle, waddr + 32'(k * BYTES_PER_WORD),
                         writedata_data[k*WORD_BITS +: WORD_BITS]);
        end
      end
      stg_valid <= rd_fire;
      if (rd_fire) begin
        for (int unsigned k = 0; k < NW; k++) begin
          stg_beat.data[k*WORD_BITS +: WORD_BITS] <=
            read_simDma32(rhandle, raddr + 32'(k * BYTES_PER_WORD));
        end
        stg_beat.tag  <= rtag;
        stg_beat.last <= rd_last;
      end
    end
  end

  xsim_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk      (CLK),
    .rst      (RST),
    .enq      (stg_valid),
    .enq_data (stg_beat),
    .deq      (rd_deq),
    .head     (head_beat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rdy_readresp  = !fifo_empty && !RST;
  assign readresp_data = rdy_readresp ? head_beat.data : '0;
  assign readresp_tag  = rdy_readresp ? head_beat.tag  : '0;
  assign readresp_last = rdy_readresp && head_beat.last;

endmodule

// File: tb/tb_xsim_dma_burst.sv
module tb_xsim_dma_burst;
  import xsim_dpi_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXB  = 16;
  localparam int unsigned TW    = 4;
  localparam int unsigned LW    = $clog2(MAXB) + 1;
  localparam int unsigned NW    = DW / 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_readreq, rdy_readreq;
  logic [31:0]   readreq_handle, readreq_addr;
  logic [LW-1:0] readreq_len;
  logic [TW-1:0] readreq_tag;
  logic          rdy_readresp, en_readresp;
  logic [DW-1:0] readresp_data;
  logic [TW-1:0] readresp_tag;
  logic          readresp_last;
  logic          en_writereq, rdy_writereq;
  logic [31:0]   writereq_handle, writereq_addr;
  logic [LW-1:0] writereq_len;
  logic [TW-1:0] writereq_tag;
  logic          en_writedata, rdy_writedata;
  logic [DW-1:0] writedata_data;
  logic          rdy_writedone, en_writedone;
  logic [TW-1:0] writedone_tag;

  always #5 clk = ~clk;

  xsim_dma_burst #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH),
    .MAXBURST  (MAXB),
    .TAGWIDTH  (TW)
  ) dut (
    .CLK             (clk),
    .RST             (rst),
    .en_readreq      (en_readreq),
    .rdy_readreq     (rdy_readreq),
    .readreq_handle  (readreq_handle),
    .readreq_addr    (readreq_addr),
    .readreq_len     (readreq_len),
    .readreq_tag     (readreq_tag),
    .rdy_readresp    (rdy_readresp),
    .en_readresp     (en_readresp),
    .readresp_data   (readresp_data),
    .readresp_tag    (readresp_tag),
    .readresp_last   (readresp_last),
    .en_writereq     (en_writereq),
    .rdy_writereq    (rdy_writereq),
    .writereq_handle (writereq_handle),
    .writereq_addr   (writereq_addr),
    .writereq_len    (writereq_len),
    .writereq_tag    (writereq_tag),
    .en_writedata    (en_writedata),
    .rdy_writedata   (rdy_writedata),
    .writedata_data  (writedata_data),
    .rdy_writedone   (rdy_writedone),
    .en_writedone    (en_writedone),
    .writedone_tag   (writedone_tag)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference host memory, keyed by {handle, byte address}.
  logic [31:0] ref_mem [logic [63:0]];

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] h, input logic [31:0] a);
    if (ref_mem.exists({h, a})) return ref_mem[{h, a}];
    return '0;
  endfunction

  task automatic poke(input logic [31:0] h, input logic [31:0] a, input logic [31:0] v);
    ref_mem[{h, a}] = v;
    host_poke(h, a, v);
  endtask

  function automatic int unsigned eff_len(input int unsigned l);
    if (l == 0) return 1;
    if (l > MAXB) return MAXB;
    return l;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input logic [31:0] h, input logic [31:0] a,
                                             input int unsigned b);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NW; k++)
      v[k*32 +: 32] = ref_word(h, a + 32'(b * (DW / 8) + 4 * k));
    return v;
  endfunction

  task automatic wait_read_ready();
    int unsigned c = 0;
    while (!rdy_readreq && c < 100) begin tick(); c++; end
    check("rdreq_ready", rdy_readreq, 1);
  endtask

  task automatic wait_write_ready();
    int unsigned c = 0;
    while (!rdy_writereq && c < 100) begin tick(); c++; end
    check("wrreq_ready", rdy_writereq, 1);
  endtask

  task automatic do_read(input logic [31:0] h, input logic [31:0] a, input int unsigned len,
                         input logic [TW-1:0] tag, input int unsigned stall_pct);
    int unsigned n, got, cyc, base;
    n = eff_len(len);
    got = 0;
    cyc = 0;
    wait_read_ready();
    base = read_calls;
    readreq_handle = h;
    readreq_addr   = a;
    readreq_len    = LW'(len);
    readreq_tag    = tag;
    en_readreq     = 1'b1;
    tick();
    en_readreq = 1'b0;
    while (got < n && cyc < 400) begin
      if (rdy_readresp && $urandom_range(99) >= stall_pct) begin
        check("rd_data", readresp_data, exp_beat(h, a, got));
        check("rd_tag", readresp_tag, tag);
        check("rd_last", readresp_last, (got == n - 1));
        en_readresp = 1'b1;
        got++;
      end else begin
        en_readresp = 1'b0;
      end
      tick();
      cyc++;
    end
    en_readresp = 1'b0;
    check("rd_beats", got, n);
    check("rd_calls", read_calls - base, n * NW);
    check("rd_drained", rdy_readresp, 0);
  endtask

  task automatic do_write(input logic [31:0] h, input logic [31:0] a, input int unsigned len,
                          input logic [TW-1:0] tag);
    int unsigned n, base, c;
    logic [31:0] ea [$];
    logic [31:0] ed [$];
    logic [DW-1:0] d;
    n = eff_len(len);
    wait_write_ready();
    base = wlog_addr.size();
    writereq_handle = h;
    writereq_addr   = a;
    writereq_len    = LW'(len);
    writereq_tag    = tag;
    en_writereq     = 1'b1;
    tick();
    en_writereq = 1'b0;
    for (int unsigned b = 0; b < n; b++) begin
      c = 0;
      while ($urandom_range(3) == 0 && c < 3) begin tick(); c++; end
      check("wr_data_ready", rdy_writedata, 1);
      for (int unsigned k = 0; k < NW; k++) begin
        d[k*32 +: 32] = $urandom;
        ea.push_back(a + 32'(b * (DW / 8) + 4 * k));
        ed.push_back(d[k*32 +: 32]);
        ref_mem[{h, a + 32'(b * (DW / 8) + 4 * k)}] = d[k*32 +: 32];
      end
      writedata_data = d;
      en_writedata   = 1'b1;
      tick();
      en_writedata = 1'b0;
    end
    check("wr_done_rdy", rdy_writedone, 1);
    check("wr_done_tag", writedone_tag, tag);
    check("wr_req_busy", rdy_writereq, 0);
    en_writedone = 1'b1;
    tick();
    en_writedone = 1'b0;
    check("wr_req_back", rdy_writereq, 1);
    check("wr_log_len", wlog_addr.size() - base, n * NW);
    for (int unsigned i = 0; i < ea.size() && base + i < wlog_addr.size(); i++) begin
      check("wr_log_addr", wlog_addr[base + i], ea[i]);
      check("wr_log_data", wlog_data[base + i], ed[i]);
      check("wr_log_hdl", wlog_handle[base + i], h);
    end
  endtask

  initial begin
    int unsigned base_r, base_w;
    logic [31:0] h, a;
    logic [DW-1:0] nd;

    rst = 1'b1;
    en_readreq = 0; en_readresp = 0; en_writereq = 0; en_writedata = 0; en_writedone = 0;
    readreq_handle = '0; readreq_addr = '0; readreq_len = '0; readreq_tag = '0;
    writereq_handle = '0; writereq_addr = '0; writereq_len = '0; writereq_tag = '0;
    writedata_data = '0;
    repeat (3) tick();
    check("rst_rdy_readreq", rdy_readreq, 0);
    check("rst_rdy_writereq", rdy_writereq, 0);
    check("rst_rdy_readresp", rdy_readresp, 0);
    check("rst_rdy_writedata", rdy_writedata, 0);
    check("rst_rdy_writedone", rdy_writedone, 0);
    check("rst_data", readresp_data, 0);
    check("rst_tag", readresp_tag, 0);
    check("rst_done_tag", writedone_tag, 0);
    rst = 1'b0;
    #1;
    check("post_rst_readreq", rdy_readreq, 1);
    check("post_rst_writereq", rdy_writereq, 1);

    // Test 1: directed read, latency, no bubbles.
    for (int unsigned i = 0; i < 8; i++) poke(32'd1, 32'h100 + 32'(4 * i), 32'h10 + 32'(i));
    base_r = read_calls;
    readreq_handle = 32'd1; readreq_addr = 32'h100; readreq_len = LW'(4); readreq_tag = 4'd3;
    en_readreq = 1'b1;
    tick();
    en_readreq = 1'b0;
    check("t1_busy", rdy_readreq, 0);
    check("t1_lat_e0", rdy_readresp, 0);
    tick();
    check("t1_lat_e1", rdy_readresp, 0);
    tick();
    check("t1_lat_e2", rdy_readresp, 1);
    for (int unsigned b = 0; b < 4; b++) begin
      check("t1_valid", rdy_readresp, 1);
      check("t1_data", readresp_data, {32'h11 + 32'(2 * b), 32'h10 + 32'(2 * b)});
      check("t1_tag", readresp_tag, 3);
      check("t1_last", readresp_last, (b == 3));
      en_readresp = 1'b1;
      tick();
    end
    en_readresp = 1'b0;
    check("t1_empty", rdy_readresp, 0);
    check("t1_idle", rdy_readreq, 1);
    check("t1_calls", read_calls - base_r, 8);

    // Test 2: backpressure holds exactly DEPTH beats outstanding.
    for (int unsigned i = 0; i < 16; i++) poke(32'd2, 32'h400 + 32'(4 * i), $urandom);
    base_r = read_calls;
    readreq_handle = 32'd2; readreq_addr = 32'h400; readreq_len = LW'(8); readreq_tag = 4'd9;
    en_readreq = 1'b1;
    tick();
    en_readreq = 1'b0;
    repeat (20) tick();
    check("t2_full_valid", rdy_readresp, 1);
    check("t2_calls_held", read_calls - base_r, DEPTH * NW);
    check("t2_busy", rdy_readreq, 0);
    for (int unsigned b = 0; b < 8; b++) begin
      check("t2_no_bubble", rdy_readresp, 1);
      check("t2_data", readresp_data, exp_beat(32'd2, 32'h400, b));
      check("t2_last", readresp_last, (b == 7));
      en_readresp = 1'b1;
      tick();
    end
    en_readresp = 1'b0;
    check("t2_empty", rdy_readresp, 0);
    check("t2_calls_all", read_calls - base_r, 16);

    // Test 3: directed write with address-ordered host calls.
    base_w = wlog_addr.size();
    writereq_handle = 32'd4; writereq_addr = 32'h200; writereq_len = LW'(2); writereq_tag = 4'd5;
    en_writereq = 1'b1;
    tick();
    en_writereq = 1'b0;
    check("t3_wdata_rdy", rdy_writedata, 1);
    writedata_data = 64'hAAAAAAAA_BBBBBBBB;
    en_writedata = 1'b1;
    tick();
    writedata_data = 64'hCCCCCCCC_DDDDDDDD;
    tick();
    en_writedata = 1'b0;
    ref_mem[{32'd4, 32'h200}] = 32'hBBBBBBBB; ref_mem[{32'd4, 32'h204}] = 32'hAAAAAAAA;
    ref_mem[{32'd4, 32'h208}] = 32'hDDDDDDDD; ref_mem[{32'd4, 32'h20C}] = 32'hCCCCCCCC;
    check("t3_log_len", wlog_addr.size() - base_w, 4);
    if (wlog_addr.size() >= base_w + 4) begin
      check("t3_a0", wlog_addr[base_w + 0], 32'h200);
      check("t3_a1", wlog_addr[base_w + 1], 32'h204);
      check("t3_a2", wlog_addr[base_w + 2], 32'h208);
      check("t3_a3", wlog_addr[base_w + 3], 32'h20C);
      check("t3_d0", wlog_data[base_w + 0], 32'hBBBBBBBB);
      check("t3_d3", wlog_data[base_w + 3], 32'hCCCCCCCC);
    end
    check("t3_done", rdy_writedone, 1);
    check("t3_done_tag", writedone_tag, 5);
    check("t3_req_busy", rdy_writereq, 0);
    en_writedone = 1'b1;
    tick();
    en_writedone = 1'b0;
    check("t3_req_back", rdy_writereq, 1);
    check("t3_done_clr", rdy_writedone, 0);

    // Test 4: address wrap, len=0, len clamp.
    poke(32'd3, 32'hFFFFFFF8, $urandom); poke(32'd3, 32'hFFFFFFFC, $urandom);
    poke(32'd3, 32'h0, $urandom);        poke(32'd3, 32'h4, $urandom);
    do_read(32'd3, 32'hFFFFFFF8, 2, 4'd6, 0);
    do_read(32'd3, 32'hFFFFFFF8, 0, 4'd7, 0);
    for (int unsigned i = 0; i < 32; i++) poke(32'd5, 32'h800 + 32'(4 * i), $urandom);
    do_read(32'd5, 32'h800, 20, 4'd8, 30);

    // Test 5: reset in the third beat of a read and in the middle of a write.
    wait_read_ready();
    wait_write_ready();
    base_r = read_calls;
    base_w = wlog_addr.size();
    readreq_handle = 32'd6; readreq_addr = 32'hA00; readreq_len = LW'(8); readreq_tag = 4'd1;
    writereq_handle = 32'd9; writereq_addr = 32'hB00; writereq_len = LW'(4); writereq_tag = 4'd2;
    en_readreq = 1'b1; en_writereq = 1'b1;
    tick();
    en_readreq = 1'b0; en_writereq = 1'b0;
    writedata_data = {32'h12345678, 32'h9ABCDEF0};
    ref_mem[{32'd9, 32'hB00}] = 32'h9ABCDEF0;
    ref_mem[{32'd9, 32'hB04}] = 32'h12345678;
    en_writedata = 1'b1;
    tick();
    en_writedata = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t5_rdy_readreq", rdy_readreq, 0);
    check("t5_rdy_writereq", rdy_writereq, 0);
    check("t5_rdy_readresp", rdy_readresp, 0);
    check("t5_rdy_writedata", rdy_writedata, 0);
    check("t5_rdy_writedone", rdy_writedone, 0);
    check("t5_data_zero", readresp_data, 0);
    check("t5_rd_calls", read_calls - base_r, 2 * NW);
    check("t5_wr_calls", wlog_addr.size() - base_w, NW);
    tick();
    rst = 1'b0;
    #1;
    check("t5_rd_calls_hold", read_calls - base_r, 2 * NW);
    check("t5_readreq_back", rdy_readreq, 1);
    check("t5_writereq_back", rdy_writereq, 1);
    check("t5_fifo_empty", rdy_readresp, 0);
    check("t5_wdata_idle", rdy_writedata, 0);
    poke(32'd6, 32'hC00, $urandom); poke(32'd6, 32'hC04, $urandom);
    do_read(32'd6, 32'hC00, 1, 4'd4, 0);

    // Test 6: same-cycle write and read of the same word.
    poke(32'd7, 32'h300, 32'h11111111);
    poke(32'd7, 32'h304, 32'h22222222);
    wait_read_ready();
    wait_write_ready();
    readreq_handle = 32'd7; readreq_addr = 32'h300; readreq_len = LW'(1); readreq_tag = 4'hA;
    writereq_handle = 32'd7; writereq_addr = 32'h300; writereq_len = LW'(1); writereq_tag = 4'hB;
    en_readreq = 1'b1; en_writereq = 1'b1;
    tick();
    en_readreq = 1'b0; en_writereq = 1'b0;
    nd = {32'h5A5A0304, 32'hA5A50300};
    ref_mem[{32'd7, 32'h300}] = nd[31:0];
    ref_mem[{32'd7, 32'h304}] = nd[63:32];
    writedata_data = nd;
    en_writedata = 1'b1;
    tick();
    en_writedata = 1'b0;
    check("t6_done", rdy_writedone, 1);
    check("t6_done_tag", writedone_tag, 4'hB);
    en_writedone = 1'b1;
    tick();
    en_writedone = 1'b0;
    check("t6_valid", rdy_readresp, 1);
    check("t6_raw_data", readresp_data, nd);
    check("t6_model_data", readresp_data, exp_beat(32'd7, 32'h300, 0));
    check("t6_tag", readresp_tag, 4'hA);
    en_readresp = 1'b1;
    tick();
    en_readresp = 1'b0;
    check("t6_empty", rdy_readresp, 0);

    // Randomized bursts against the reference memory.
    for (int unsigned it = 0; it < 16; it++) begin
      int unsigned len;
      h = 32'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFC0 + 32'(4 * $urandom_range(0, 15))
                                      : {$urandom, 2'b00};
      len = $urandom_range(0, 20);
      for (int unsigned i = 0; i < eff_len(len) * NW; i++) poke(h, a + 32'(4 * i), $urandom);
      if ($urandom_range(1) == 1)
        do_write(h, a, $urandom_range(0, 20), 4'($urandom));
      do_read(h, a, len, 4'($urandom), $urandom_range(0, 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
